// File: rtl/sample_capture_dump.sv
// Multi-channel sample capture buffer with UART-style hex dump.
// Captures NUM_SAMPLES vectors on 's', then streams each as one line of uppercase hex ASCII.
module sample_capture_dump #(
  parameter int SAMPLE_BITLEN = 24,
  parameter int NUM_CHANNELS  = 2,
  parameter int NUM_SAMPLES   = 4096,
  parameter int DECIMATE      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CHANNELS*SAMPLE_BITLEN-1:0] sample_in,
  input  logic                                  sample_valid,
  input  logic                                  rx_valid,
  output logic                                  rx_ready,
  input  logic [7:0]                            rx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic [7:0]                            tx_data,
  output logic                                  busy,
  output logic                                  capture_done,
  output logic [2:0]                            state_dbg
);

  localparam int NIB = (SAMPLE_BITLEN + 3) / 4;
  localparam int W   = NUM_CHANNELS * SAMPLE_BITLEN;
  localparam int AW  = $clog2(NUM_SAMPLES);
  localparam int DW  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int CW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int GW  = $clog2(NIB + 1);

  // The DUMP phase is split into read-address, line-load and byte-transmit substates.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_DUMP_RD = 3'd2,
    S_DUMP_LD = 3'd3,
    S_DUMP_TX = 3'd4
  } state_t;

  state_t state, state_n;

  logic [W-1:0]  mem [NUM_SAMPLES];
  logic [W-1:0]  ram_q;
  logic [W-1:0]  line_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] dec_cnt;
  logic [CW-1:0] ch_cnt;
  logic [GW-1:0] dig_cnt;
  logic          lf_phase;
  logic          abort_pend;

  logic [7:0] cmd_lc;
  logic       cmd_s, cmd_r, cmd_x;
  logic       store, last_store, hs, last_line, sep_slot, last_ch;

  logic [SAMPLE_BITLEN-1:0] chan;
  logic [4*NIB-1:0]         chan_ext;
  logic [3:0]               nib;
  logic [7:0]               byte_n;

  // OR-ing 0x20 folds 'S'/'R'/'X' onto lowercase without aliasing any other byte.
  assign cmd_lc = rx_data | 8'h20;
  assign cmd_s  = rx_valid && (cmd_lc == 8'h73);
  assign cmd_r  = rx_valid && (cmd_lc == 8'h72);
  assign cmd_x  = rx_valid && (cmd_lc == 8'h78);

  assign store      = (state == S_CAPTURE) && sample_valid && (dec_cnt == '0);
  assign last_store = store && (wr_idx == AW'(NUM_SAMPLES - 1));
  assign hs         = tx_valid && tx_ready;
  assign last_line  = (rd_idx == AW'(NUM_SAMPLES - 1));
  assign sep_slot   = (dig_cnt == GW'(NIB));
  assign last_ch    = (ch_cnt == CW'(NUM_CHANNELS - 1));

  assign rx_ready  = 1'b1;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (cmd_s)                     state_n = S_CAPTURE;
        else if (cmd_r && capture_done) state_n = S_DUMP_RD;
      end
      S_CAPTURE: begin
        if (cmd_x)           state_n = S_IDLE;
        else if (last_store) state_n = S_DUMP_RD;
      end
      S_DUMP_RD: state_n = cmd_x ? S_IDLE : S_DUMP_LD;
      S_DUMP_LD: state_n = cmd_x ? S_IDLE : S_DUMP_TX;
      S_DUMP_TX: begin
        if (hs) begin
          if (cmd_x || abort_pend || (lf_phase && last_line)) state_n = S_IDLE;
          else if (lf_phase)                                  state_n = S_DUMP_RD;
        end else if (!tx_valid && cmd_x) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Character for the current line position: hex digit, separator, CR or LF.
  always_comb begin
    chan     = '0;
    chan_ext = '0;
    nib      = 4'h0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (CW'(c) == ch_cnt) chan = line_q[c*SAMPLE_BITLEN +: SAMPLE_BITLEN];
    chan_ext[SAMPLE_BITLEN-1:0] = chan;
    for (int d = 0; d < NIB; d++)
      if (GW'(d) == dig_cnt) nib = chan_ext[4*(NIB-1-d) +: 4];
    if (lf_phase)          byte_n = 8'h0A;
    else if (sep_slot)     byte_n = last_ch ? 8'h0D : 8'h2C;
    else if (nib < 4'd10)  byte_n = {4'h3, nib};
    else                   byte_n = 8'h37 + {4'h0, nib};
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_idx] <= sample_in;
  end

  always_ff @(posedge clk) begin
    ram_q <= mem[rd_idx];
  end

  // tx handshake: tx_valid/tx_data hold until tx_valid&tx_ready; tx_valid is low for at
  // least the cycle after each handshake, so every byte takes two cycles or more.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      capture_done <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      dec_cnt      <= '0;
      ch_cnt       <= '0;
      dig_cnt      <= '0;
      lf_phase     <= 1'b0;
      abort_pend   <= 1'b0;
      line_q       <= '0;
    end else begin
      if (cmd_x) capture_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_s) begin
            capture_done <= 1'b0;
            wr_idx       <= '0;
            dec_cnt      <= '0;
          end else if (cmd_r && capture_done) begin
            rd_idx     <= '0;
            ch_cnt     <= '0;
            dig_cnt    <= '0;
            lf_phase   <= 1'b0;
            abort_pend <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (sample_valid)
            dec_cnt <= (dec_cnt == DW'(DECIMATE - 1)) ? '0 : dec_cnt + 1'b1;
          if (store) wr_idx <= wr_idx + 1'b1;
          if (last_store && !cmd_x) begin
            capture_done <= 1'b1;
            rd_idx       <= '0;
            ch_cnt       <= '0;
            dig_cnt      <= '0;
            lf_phase     <= 1'b0;
            abort_pend   <= 1'b0;
          end
        end
        S_DUMP_LD: line_q <= ram_q;
        S_DUMP_TX: begin
          if (!tx_valid) begin
            if (!cmd_x) begin
              tx_valid <= 1'b1;
              tx_data  <= byte_n;
            end
          end else if (hs) begin
            tx_valid <= 1'b0;
            if (lf_phase) begin
              lf_phase <= 1'b0;
              ch_cnt   <= '0;
              dig_cnt  <= '0;
              rd_idx   <= rd_idx + 1'b1;
            end else if (sep_slot) begin
              dig_cnt <= '0;
              if (last_ch) lf_phase <= 1'b1;
              else         ch_cnt   <= ch_cnt + 1'b1;
            end else begin
              dig_cnt <= dig_cnt + 1'b1;
            end
          end else if (cmd_x) begin
            abort_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
